// File: rtl/decoder_4to16_strobe_if.sv
// Handshake and strobe bus of decoder_4to16_strobe: code in, one-hot line strobe out.
// The producer/observer side uses the master modport and the decoder uses the slave modport.
interface decoder_4to16_strobe_if;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned LINE_W = 16;

  logic              en;
  logic              scan;
  logic [CODE_W-1:0] d;
  logic              in_valid;
  logic              in_ready;
  logic [LINE_W-1:0] o;
  logic              o_valid;
  logic              done;

  modport master (
    output en, scan, d, in_valid,
    input  in_ready, o, o_valid, done
  );

  modport slave (
    input  en, scan, d, in_valid,
    output in_ready, o, o_valid, done
  );
endinterface

// File: rtl/decoder_4to16_strobe.sv
// Sequenced 4-to-16 one-hot strobe decoder with programmable hold and guard gap.
// Optional self-walking scan mode is built only when DEC_SCAN_EN is defined.
module decoder_4to16_strobe #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned GAP  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  decoder_4to16_strobe_if.slave  bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned LINE_W = 16;

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = (GAP == 0) ? '0 : CNT_W'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   o_q, o_d;
  logic                o_valid_q, o_valid_d;
  logic                done_q, done_d;

  logic                scan_act_c;
  logic [CODE_W-1:0]   code_c;
  logic                accept_c;
  logic                strobe_end_c;
  logic                abort_c;

`ifdef DEC_SCAN_EN
  logic [CODE_W-1:0]   scnt_q, scnt_d;
  logic                scan_strobe_q, scan_strobe_d;

  assign scan_act_c = bus.scan & bus.en;
  assign code_c     = scan_act_c ? scnt_q : bus.d;
`else
  logic                unused_scan;

  assign unused_scan = bus.scan;
  assign scan_act_c  = 1'b0;
  assign code_c      = bus.d;
`endif

  // Handshake readiness depends only on state, en and scan, never on in_valid.
  assign bus.in_ready = (state_q == ST_IDLE) & bus.en & ~scan_act_c;
  assign accept_c     = (state_q == ST_IDLE) & bus.en & (scan_act_c | bus.in_valid);
  assign strobe_end_c = (state_q == ST_HOLD) & bus.en & (cnt_q == '0);
  assign abort_c      = (state_q != ST_IDLE) & ~bus.en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          o_d       = LINE_W'(1) << code_c;
          o_valid_d = 1'b1;
          cnt_d     = HOLD_M1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!bus.en) begin
          o_d       = '0;
          o_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          o_d       = '0;
          o_valid_d = 1'b0;
          done_d    = 1'b1;
          if (GAP != 0) begin
            cnt_d   = GAP_M1;
            state_d = ST_GAP;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (!bus.en) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        o_d       = '0;
        o_valid_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

`ifdef DEC_SCAN_EN
  // Advance the walk only when a strobe launched by scan completes normally.
  always_comb begin
    scnt_d        = scnt_q;
    scan_strobe_d = scan_strobe_q;
    if (accept_c) begin
      scan_strobe_d = scan_act_c;
    end else if (strobe_end_c) begin
      scan_strobe_d = 1'b0;
      if (scan_strobe_q) begin
        scnt_d = scnt_q + CODE_W'(1);
      end
    end else if (abort_c) begin
      scan_strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q        <= '0;
      scan_strobe_q <= 1'b0;
    end else begin
      scnt_q        <= scnt_d;
      scan_strobe_q <= scan_strobe_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_decoder_4to16_strobe.sv
// Directed bench for decoder_4to16_strobe: one instance with HOLD=4/GAP=1, one with HOLD=1/GAP=0.
module tb_decoder_4to16_strobe;

  localparam int unsigned HOLD_A = 4;
  localparam int unsigned GAP_A  = 1;
  localparam int unsigned HOLD_B = 1;
  localparam int unsigned GAP_B  = 0;
  localparam int          TMO    = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_4to16_strobe_if ifa ();
  decoder_4to16_strobe_if ifb ();

  decoder_4to16_strobe #(.HOLD(HOLD_A), .GAP(GAP_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  decoder_4to16_strobe #(.HOLD(HOLD_B), .GAP(GAP_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;
  int done_a   = 0;
  int cyc      = 0;
  logic [15:0] exp_q[$];
  logic [15:0] expb_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ifa.done === 1'b1) done_a <= done_a + 1;

  function automatic logic [15:0] onehot(input logic [3:0] c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = (i == int'(c));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; holds the code until the decoder accepts it.
  task automatic send_a(input logic [3:0] code, output int acc_cyc);
    int t = 0;
    ifa.d        = code;
    ifa.in_valid = 1'b1;
    while (ifa.in_ready !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk("a_ready_wait", 32'(ifa.in_ready), 32'd1);
    exp_q.push_back(onehot(code));
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    ifa.in_valid = 1'b0;
  endtask

  task automatic expect_a(input string tag);
    int t = 0;
    logic [15:0] exp;
    @(negedge clk);
    while (ifa.o_valid !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ov"}, 32'(ifa.o_valid), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
    chk({tag, "_o"}, 32'(ifa.o), 32'(exp));
    for (int i = 1; i < int'(HOLD_A); i++) begin
      @(negedge clk);
      chk({tag, "_hold_o"}, 32'(ifa.o), 32'(exp));
      chk({tag, "_hold_done"}, 32'(ifa.done), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_end_o"}, 32'(ifa.o), 32'd0);
    chk({tag, "_end_ov"}, 32'(ifa.o_valid), 32'd0);
    chk({tag, "_done"}, 32'(ifa.done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, snap;
    logic [3:0] code;
    logic [15:0] e;

    ifa.en = 1'b0; ifa.scan = 1'b0; ifa.d = '0; ifa.in_valid = 1'b0;
    ifb.en = 1'b0; ifb.scan = 1'b0; ifb.d = '0; ifb.in_valid = 1'b0;

    // Reset state
    #2;
    chk("rst_o",       32'(ifa.o),        32'd0);
    chk("rst_ov",      32'(ifa.o_valid),  32'd0);
    chk("rst_done",    32'(ifa.done),     32'd0);
    chk("rst_rdy",     32'(ifa.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    ifa.en = 1'b1;
    ifb.en = 1'b1;
    #1;
    chk("post_rst_rdy", 32'(ifa.in_ready), 32'd1);
    @(negedge clk);

    // Single strobe d=A, then ready returns after the gap
    send_a(4'hA, c0);
    expect_a("t1");
    chk("t1_gap_rdy", 32'(ifa.in_ready), 32'd0);
    @(negedge clk);
    chk("t1_idle_rdy", 32'(ifa.in_ready), 32'd1);
    chk("t1_idle_o",   32'(ifa.o),        32'd0);

    // Back-to-back at minimum spacing
    snap = done_a;
    send_a(4'h0, c0);
    expect_a("b2b0");
    send_a(4'hF, c1);
    chk("b2b_spacing", 32'(c1 - c0), 32'(HOLD_A + GAP_A + 1));
    expect_a("b2b1");
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done_cnt", 32'(done_a - snap), 32'd2);

    // Sweep all codes
    snap = done_a;
    for (int c = 0; c < 16; c++) begin
      send_a(4'(c), c0);
      expect_a("sweep");
    end
    @(negedge clk);
    @(negedge clk);
    chk("sweep_done_cnt", 32'(done_a - snap), 32'd16);

    // en dropped in HOLD cycle 2 of 4
    snap = done_a;
    send_a(4'h3, c0);
    e = exp_q.pop_front();
    @(negedge clk);
    chk("endrop_o1", 32'(ifa.o), 32'(e));
    @(negedge clk);
    chk("endrop_o2", 32'(ifa.o), 32'h0008);
    ifa.en = 1'b0;
    @(negedge clk);
    chk("endrop_o",   32'(ifa.o),        32'd0);
    chk("endrop_ov",  32'(ifa.o_valid),  32'd0);
    chk("endrop_rdy", 32'(ifa.in_ready), 32'd0);
    repeat (HOLD_A + 2) @(negedge clk);
    chk("endrop_no_done", 32'(done_a - snap), 32'd0);
    ifa.en = 1'b1;
    #1;
    chk("endrop_rdy_back", 32'(ifa.in_ready), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-HOLD
    snap = done_a;
    send_a(4'h7, c0);
    e = exp_q.pop_front();
    @(negedge clk);
    chk("rstmid_o_pre", 32'(ifa.o), 32'(e));
    chk("rstmid_o_0080", 32'(ifa.o), 32'h0080);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_o",    32'(ifa.o),       32'd0);
    chk("rstmid_ov",   32'(ifa.o_valid), 32'd0);
    chk("rstmid_done", 32'(ifa.done),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD_A + 2) @(negedge clk);
    chk("rstmid_no_done", 32'(done_a - snap), 32'd0);
    chk("rstmid_idle_rdy", 32'(ifa.in_ready), 32'd1);
    chk("rstmid_idle_o",   32'(ifa.o),        32'd0);

    // HOLD=1 GAP=0 with continuous in_valid: accept every second cycle
    ifb.in_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("b_ov_phase", 32'(ifb.o_valid), 32'(j % 2));
      if (ifb.o_valid === 1'b1) begin
        e = (expb_q.size() != 0) ? expb_q.pop_front() : 16'h0000;
        chk("b_o", 32'(ifb.o), 32'(e));
      end else begin
        chk("b_gap_o", 32'(ifb.o), 32'd0);
        chk("b_gap_rdy", 32'(ifb.in_ready), 32'd1);
        if (j > 0) chk("b_done", 32'(ifb.done), 32'd1);
      end
      if (ifb.in_ready === 1'b1) begin
        code   = 4'(j * 7 + 3);
        ifb.d  = code;
        expb_q.push_back(onehot(code));
      end
      @(negedge clk);
    end
    ifb.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_drained_o", 32'(ifb.o), 32'd0);
    chk("b_drained_rdy", 32'(ifb.in_ready), 32'd1);

`ifdef DEC_SCAN_EN
    // Scan walk on HOLD=1 GAP=0 instance, including the wrap to code 0
    ifb.scan = 1'b1;
    #1;
    chk("scan_rdy0", 32'(ifb.in_ready), 32'd0);
    for (int s = 0; s < 17; s++) begin
      @(negedge clk);
      chk("scan_o",   32'(ifb.o),        32'(onehot(4'(s % 16))));
      chk("scan_rdy", 32'(ifb.in_ready), 32'd0);
      @(negedge clk);
      chk("scan_gap_o", 32'(ifb.o),        32'd0);
      chk("scan_done",  32'(ifb.done),     32'd1);
      chk("scan_rdy",   32'(ifb.in_ready), 32'd0);
    end
    ifb.scan = 1'b0;
    @(negedge clk);
    chk("scan_off_o",   32'(ifb.o),        32'd0);
    chk("scan_off_rdy", 32'(ifb.in_ready), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_4to16_strobe.md
# decoder_4to16_strobe

Sequenced 4-to-16 one-hot decoder: accepts a 4-bit code over a valid/ready handshake and drives the matching one-hot line of a 16-bit output for a programmable number of cycles, followed by a programmable guard gap. It is the decode-side counterpart to the team's 16-to-4 enable encoders and drives row/line-select strobes onto downstream one-hot buses. An optional scan mode self-generates codes 0..15 cyclically for line-walk tests.

## Interface
- HOLD, default 4: cycles the one-hot line stays asserted; legal range 1..255.
- GAP, default 1: all-zero cycles after each strobe before the next accept; legal range 0..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; low forces the block idle.
- d  in  4  code to decode; sampled on accept.
- in_valid  in  1  producer has a code on d.
- in_ready  out  1  block can accept; `(state==IDLE) & en`, scan inactive.
- scan  in  1  scan-mode request (see Configuration).
- o  out  16  one-hot output; all-zero when not strobing.
- o_valid  out  1  high exactly when o is non-zero.
- done  out  1  one-cycle pulse when a strobe completes normally.

## Operation
- States: IDLE, HOLD, GAP. A registered 8-bit down-counter `cnt` and a 4-bit scan counter `scnt` are kept.
- Reset (async, rst_n=0): state=IDLE, o=0, o_valid=0, done=0, cnt=0, scnt=0. in_ready evaluates to 0 until after reset is released and en=1.
- IDLE: accept when in_valid & in_ready. On the accept edge: o <= 16'b1 << d, o_valid <= 1, cnt <= HOLD-1, state <= HOLD. in_valid while in_ready=0 is ignored. The producer must hold it.
- HOLD: o is held constant. If cnt != 0, decrement. If cnt == 0: o <= 0, o_valid <= 0, done <= 1 for one cycle. Then the state becomes GAP with cnt <= GAP-1 when GAP > 0, or IDLE when GAP == 0.
- GAP: o=0. Decrement cnt and move to IDLE when cnt == 0.
- done is registered and is 0 in every other cycle.
- en deasserted in HOLD or GAP: at the next edge, o <= 0, o_valid <= 0, state <= IDLE. No done pulse. cnt is cleared.
- en deasserted in IDLE: in_ready=0 and no accept occurs.
- Reset mid-strobe: o clears immediately (asynchronously). No done pulse.
- d is captured only at accept. Changes to d during HOLD have no effect.
- Every output except in_ready is a flop output. in_ready is combinational from state, en and scan only, and never from in_valid.

## Timing
- The accept edge at cycle k puts o at its value from k+1 through k+HOLD inclusive. At edge k+HOLD+1, o=0 and done=1 for that cycle.
- in_ready becomes high again GAP cycles after done.
- Minimum spacing between accept edges is HOLD+GAP+1 cycles.
- Example: HOLD=1, GAP=0 gives one accept every 2 cycles.

## Configuration
- DEC_SCAN_EN defined:
  - With scan=1 and en=1, in IDLE the block self-accepts code scnt (in_ready=0, in_valid ignored) and increments scnt by 1 when done pulses.
  - scnt wraps from 15 to 0.
  - Deasserting scan lets the current strobe finish. scnt keeps its value.
  - scan toggled mid-HOLD does not affect the current strobe.
- DEC_SCAN_EN undefined: scan is ignored, scnt is not built, and the behaviour is the handshake path only.

## Test plan
- HOLD=4, GAP=1. Reset, en=1, accept d=4'hA at edge k → o=16'h0400, o_valid=1 over cycles k+1..k+4. At k+5, o=0 and done=1. in_ready=1 again at k+6.
- Back-to-back: in_valid held high with d=0 then d=15 → o=16'h0001, then after HOLD+GAP+1 cycles o=16'h8000. Exactly two done pulses. All 16 codes swept give the correct one-hot pattern.
- HOLD=1, GAP=0, continuous in_valid → an accept every 2 cycles, o alternating between the code's one-hot value and 0.
- en dropped during HOLD cycle 2 of 4 (d=3) → o=0 at the next edge, no done pulse, in_ready=1 once en returns.
- rst_n pulsed low mid-HOLD (d=7, o=16'h0080) → o=0 asynchronously before the next clock, state IDLE, no done pulse.
- DEC_SCAN_EN, scan=1, en=1, HOLD=1, GAP=0 → o walks 16'h0001, 16'h0002 … 16'h8000, then 16'h0001. in_ready stays 0 throughout.
